word_serializer16: RTL

// - Parallel-to-serial transmitter for 16-bit words: the send-side counterpart of the

---
 rtl/word_serializer16_pkg.sv | 14 +
 rtl/word_serializer16_piso.sv | 38 +++
 rtl/word_serializer16.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/word_serializer16_pkg.sv
// Shared definitions for the word_serializer16 transmitter.
//   WORD_WIDTH : default word length in bits
//   state_t    : transmitter FSM encoding (idle / shifting / inter-frame gap)
package word_serializer16_pkg;

  localparam int WORD_WIDTH = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

endpackage

// File: rtl/word_serializer16_piso.sv
// piso16: parallel-load shift register feeding the serial output.
//   clk, reset : clock, asynchronous active-high clear
//   load       : capture d (has priority over shift)
//   shift      : advance one bit, filling with zeros
//   d          : parallel word
//   q_bit      : bit currently presented (bit 0 when LSB_FIRST, else bit WIDTH-1)
// Zero fill means that once a full word has been shifted out the register
// reads all zeros, so q_bit is naturally 0 between frames.
module piso16
  import word_serializer16_pkg::*;
#(
  parameter int WIDTH     = WORD_WIDTH,
  parameter bit LSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] d,
  output logic             q_bit
);

  logic [WIDTH-1:0] sh;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh <= '0;
    end else if (load) begin
      sh <= d;
    end else if (shift) begin
      if (LSB_FIRST) sh <= {1'b0, sh[WIDTH-1:1]};
      else           sh <= {sh[WIDTH-2:0], 1'b0};
    end
  end

  assign q_bit = LSB_FIRST ? sh[0] : sh[WIDTH-1];

endmodule

// File: rtl/word_serializer16.sv
// word_serializer16: parallel-to-serial transmitter with a one-word holding buffer.
//   clk, reset  : clock, asynchronous active-high reset
//   in          : parallel word to transmit
//   in_valid    : in holds a word
//   in_ready    : block can take a word this cycle
//   sout        : serial data bit
//   sout_valid  : sout carries a data bit this cycle
//   sof         : high with the first bit of each word
//   busy        : a word is shifting, in gap, or held in the buffer
//   dbg_state   : current FSM state, for observation only
//
// Handshake: a word transfers on a rising clk edge where in_valid && in_ready.
// in_ready is decoded from registers only (!buf_full) and never depends on
// in_valid; in is ignored on edges without a transfer. Once raised, in_ready
// stays high until a transfer fills the buffer.
//
// Frames: the first bit appears the cycle after the loading edge, then one bit
// per cycle for WIDTH cycles, followed by GAP_CYCLES idle cycles. At a frame
// start point the buffered word wins; a word arriving on that same edge goes
// into the buffer, or straight into the shifter if the buffer was empty.
module word_serializer16
  import word_serializer16_pkg::*;
#(
  parameter int WIDTH      = WORD_WIDTH,
  parameter bit LSB_FIRST  = 1'b1,
  parameter int GAP_CYCLES = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sof,
  output logic             busy,
  output state_t           dbg_state
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  state_t           state, state_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic [GW-1:0]    gcnt, gcnt_n;
  logic [WIDTH-1:0] hold_q, hold_n;
  logic             buf_full, buf_full_n;
  logic             load, shift;
  logic [WIDTH-1:0] load_data;
  logic             start_pt;
  logic             accept;
  logic             last_bit, gap_done;
  logic             sout_valid_q, sof_q, busy_q;

  assign accept   = in_valid && !buf_full;
  assign last_bit = (cnt == CW'(WIDTH-1));
  assign gap_done = (gcnt == GW'(GAP_CYCLES-1));

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    gcnt_n     = gcnt;
    hold_n     = hold_q;
    buf_full_n = buf_full;
    load       = 1'b0;
    shift      = 1'b0;
    load_data  = hold_q;
    start_pt   = 1'b0;

    case (state)
      ST_IDLE: start_pt = 1'b1;
      ST_SHIFT: begin
        // The shift on the last bit empties the shifter, keeping sout at 0
        // until the next load.
        shift = 1'b1;
        cnt_n = cnt + CW'(1);
        if (last_bit) begin
          cnt_n = '0;
          if (GAP_CYCLES > 0) begin
            state_n = ST_GAP;
            gcnt_n  = '0;
          end else begin
            start_pt = 1'b1;
          end
        end
      end
      ST_GAP: begin
        gcnt_n = gcnt + GW'(1);
        if (gap_done) start_pt = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    if (start_pt) begin
      cnt_n = '0;
      if (buf_full) begin
        load       = 1'b1;
        load_data  = hold_q;
        buf_full_n = 1'b0;
        state_n    = ST_SHIFT;
      end else if (accept) begin
        load      = 1'b1;
        load_data = in;
        state_n   = ST_SHIFT;
      end else begin
        state_n = ST_IDLE;
      end
    end

    // Any accepted word that did not go straight into the shifter is held.
    if (accept && !(start_pt && !buf_full)) begin
      hold_n     = in;
      buf_full_n = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      cnt          <= '0;
      gcnt         <= '0;
      hold_q       <= '0;
      buf_full     <= 1'b0;
      sout_valid_q <= 1'b0;
      sof_q        <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state        <= state_n;
      cnt          <= cnt_n;
      gcnt         <= gcnt_n;
      hold_q       <= hold_n;
      buf_full     <= buf_full_n;
      sout_valid_q <= (state_n == ST_SHIFT);
      sof_q        <= load;
      busy_q       <= (state_n != ST_IDLE) || buf_full_n;
    end
  end

  piso16 #(
    .WIDTH     (WIDTH),
    .LSB_FIRST (LSB_FIRST)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .shift (shift),
    .d     (load_data),
    .q_bit (sout)
  );

  assign in_ready   = !buf_full;
  assign sout_valid = sout_valid_q;
  assign sof        = sof_q;
  assign busy       = busy_q;
  assign dbg_state  = state;

endmodule
